mouse_master_sm: RTL and testbench

//  Top-level sequencer for the PS/2 mouse link. Drives the host->device byte transmitter and the

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/mouse_master_sm.sv | 207 ++++++++++++++++++++
 tb/tb_mouse_master_sm.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 mouse link: sequencer state encodings,
// host command bytes, expected device replies and receiver error-flag bits.
// ----------------------------------------------------------------------------
package ps2_pkg;

    // Sequencer states; the numeric codes are visible on the debug state port.
    typedef enum logic [3:0] {
        StInit     = 4'd0,
        StSendRst  = 4'd1,
        StWaitTx1  = 4'd2,
        StWaitAck1 = 4'd3,
        StWaitBat  = 4'd4,
        StWaitId   = 4'd5,
        StSendEn   = 4'd6,
        StWaitTx2  = 4'd7,
        StWaitAck2 = 4'd8,
        StRxStat   = 4'd9,
        StRxDx     = 4'd10,
        StRxDy     = 4'd11,
        StIrq      = 4'd12
    } ms_state_e;

    // Host -> device commands
    localparam logic [7:0] CmdReset  = 8'hFF;
    localparam logic [7:0] CmdEnable = 8'hF4;

    // Device -> host replies
    localparam logic [7:0] RspAck    = 8'hFA;
    localparam logic [7:0] RspBatOk  = 8'hAA;
    localparam logic [7:0] RspIdStd  = 8'h00;

    // Receiver error-code bit positions
    localparam int unsigned ErrParityBit = 0;
    localparam int unsigned ErrStopBit   = 1;

    localparam int unsigned CntWidth = 26;

endpackage

// File: rtl/mouse_master_sm.sv
// ----------------------------------------------------------------------------
// mouse_master_sm
// Top-level sequencer for the PS/2 mouse link. Resets the mouse, checks the
// self-test and ID replies, enables streaming, then assembles 3-byte movement
// packets and presents them with a one-cycle interrupt pulse.
//
// Ports
//   clk_i              system clock
//   rst_i              asynchronous active-high reset
//   send_byte_o        one-cycle request to the transmitter
//   byte_to_send_o     command byte, valid while send_byte_o is high
//   byte_sent_i        one-cycle pulse: transmitter finished
//   read_enable_o      receiver enable
//   byte_read_i        received byte, valid with byte_ready_i
//   byte_error_code_i  receiver error flags (bit0 parity, bit1 stop)
//   byte_ready_i       one-cycle pulse: byte received
//   mouse_status_o     packet byte 0
//   mouse_dx_o         packet byte 1
//   mouse_dy_o         packet byte 2
//   send_interrupt_o   one-cycle pulse: new packet on mouse_* outputs
//   master_state_o     current state code (debug)
// ----------------------------------------------------------------------------
module mouse_master_sm
    import ps2_pkg::*;
#(
    parameter int unsigned InitDelay = 5_000_000,
    parameter int unsigned RxTimeout = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       send_byte_o,
    output logic [7:0] byte_to_send_o,
    input  logic       byte_sent_i,
    output logic       read_enable_o,
    input  logic [7:0] byte_read_i,
    input  logic [1:0] byte_error_code_i,
    input  logic       byte_ready_i,
    output logic [7:0] mouse_status_o,
    output logic [7:0] mouse_dx_o,
    output logic [7:0] mouse_dy_o,
    output logic       send_interrupt_o,
    output logic [3:0] master_state_o
);

    localparam logic [CntWidth-1:0] InitLast    = CntWidth'(InitDelay - 1);
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(RxTimeout - 1);

    ms_state_e             state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [7:0]            sh_status_q, sh_status_d;
    logic [7:0]            sh_dx_q, sh_dx_d;
    logic [7:0]            sh_dy_q, sh_dy_d;
    logic [7:0]            status_q, status_d;
    logic [7:0]            dx_q, dx_d;
    logic [7:0]            dy_q, dy_d;
    logic                  irq_q, irq_d;
    logic                  send_q, send_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rx_clean;
    logic                  init_phase;

    assign rx_clean   = (byte_error_code_i == 2'b00);
    assign init_phase = (state_q inside {StWaitTx1, StWaitAck1, StWaitBat, StWaitId,
                                         StSendEn, StWaitTx2, StWaitAck2});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        sh_status_d = sh_status_q;
        sh_dx_d     = sh_dx_q;
        sh_dy_d     = sh_dy_q;
        status_d    = status_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        irq_d       = 1'b0;

        unique case (state_q)
            StInit: begin
                if (cnt_q == InitLast) state_d = StSendRst;
            end
            StSendRst: state_d = StWaitTx1;
            StWaitTx1: begin
                if (byte_sent_i) state_d = StWaitAck1;
            end
            StWaitAck1: begin
                if (byte_ready_i) begin
                    state_d = (rx_clean && byte_read_i == RspAck) ? StWaitBat : StInit;
                end
            end
            StWaitBat: begin
                if (byte_ready_i) begin
                    state_d = (rx_clean && byte_read_i == RspBatOk) ? StWaitId : StInit;
                end
            end
            StWaitId: begin
                if (byte_ready_i) begin
                    state_d = (rx_clean && byte_read_i == RspIdStd) ? StSendEn : StInit;
                end
            end
            StSendEn: state_d = StWaitTx2;
            StWaitTx2: begin
                if (byte_sent_i) state_d = StWaitAck2;
            end
            StWaitAck2: begin
                if (byte_ready_i) begin
                    state_d = (rx_clean && byte_read_i == RspAck) ? StRxStat : StInit;
                end
            end
            StRxStat: begin
                if (byte_ready_i) begin
                    if (rx_clean) begin
                        sh_status_d = byte_read_i;
                        state_d     = StRxDx;
                    end else begin
                        state_d = StInit;
                    end
                end
            end
            StRxDx: begin
                if (byte_ready_i) begin
                    if (rx_clean) begin
                        sh_dx_d = byte_read_i;
                        state_d = StRxDy;
                    end else begin
                        state_d = StInit;
                    end
                end
            end
            StRxDy: begin
                if (byte_ready_i) begin
                    if (rx_clean) begin
                        sh_dy_d = byte_read_i;
                        state_d = StIrq;
                    end else begin
                        state_d = StInit;
                    end
                end
            end
            StIrq: begin
                // Outputs only ever change here, so a broken packet never leaks out.
                status_d = sh_status_q;
                dx_d     = sh_dx_q;
                dy_d     = sh_dy_q;
                irq_d    = 1'b1;
                state_d  = StRxStat;
            end
            default: state_d = StInit;
        endcase

        // Init-phase watchdog: a silent or stuck device sends us back to retry.
        if (init_phase && state_d == state_q && cnt_q == TimeoutLast) begin
            state_d = StInit;
        end

        // Counter restarts on every transition; idle while streaming.
        if (state_d != state_q || state_q inside {StRxStat, StRxDx, StRxDy, StIrq}) begin
            cnt_d = '0;
        end

        // Registered command/enable outputs track the state being entered.
        send_d    = (state_d == StSendRst) || (state_d == StSendEn);
        tx_byte_d = (state_d == StSendRst) ? CmdReset :
                    (state_d == StSendEn)  ? CmdEnable : 8'h00;
        rd_en_d   = !(state_d inside {StInit, StSendRst});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            sh_status_q <= 8'h00;
            sh_dx_q     <= 8'h00;
            sh_dy_q     <= 8'h00;
            status_q    <= 8'h00;
            dx_q        <= 8'h00;
            dy_q        <= 8'h00;
            irq_q       <= 1'b0;
            send_q      <= 1'b0;
            tx_byte_q   <= 8'h00;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_status_q <= sh_status_d;
            sh_dx_q     <= sh_dx_d;
            sh_dy_q     <= sh_dy_d;
            status_q    <= status_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            irq_q       <= irq_d;
            send_q      <= send_d;
            tx_byte_q   <= tx_byte_d;
            rd_en_q     <= rd_en_d;
        end
    end

    assign send_byte_o      = send_q;
    assign byte_to_send_o   = tx_byte_q;
    assign read_enable_o    = rd_en_q;
    assign mouse_status_o   = status_q;
    assign mouse_dx_o       = dx_q;
    assign mouse_dy_o       = dy_q;
    assign send_interrupt_o = irq_q;
    assign master_state_o   = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// ----------------------------------------------------------------------------
// tb_mouse_master_sm
// Scoreboarded bench for mouse_master_sm: expected commands and packets are
// queued as stimulus is driven and popped when the DUT pulses its outputs.
// ----------------------------------------------------------------------------
module tb_mouse_master_sm;

    localparam int unsigned InitDelay = 10;
    localparam int unsigned RxTimeout = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send_byte;
    logic [7:0] byte_to_send;
    logic       byte_sent = 1'b0;
    logic       read_enable;
    logic [7:0] byte_read = 8'h00;
    logic [1:0] byte_err = 2'b00;
    logic       byte_ready = 1'b0;
    logic [7:0] m_status, m_dx, m_dy;
    logic       send_irq;
    logic [3:0] m_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  cmd_q[$];
    logic [23:0] pkt_q[$];

    always #5 clk = ~clk;

    mouse_master_sm #(
        .InitDelay(InitDelay),
        .RxTimeout(RxTimeout)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .send_byte_o      (send_byte),
        .byte_to_send_o   (byte_to_send),
        .byte_sent_i      (byte_sent),
        .read_enable_o    (read_enable),
        .byte_read_i      (byte_read),
        .byte_error_code_i(byte_err),
        .byte_ready_i     (byte_ready),
        .mouse_status_o   (m_status),
        .mouse_dx_o       (m_dx),
        .mouse_dy_o       (m_dy),
        .send_interrupt_o (send_irq),
        .master_state_o   (m_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every command pulse and interrupt must match a queued entry.
    always @(negedge clk) begin
        if (send_byte) begin
            if (cmd_q.size() > 0) check_eq("cmd_byte", {24'h0, byte_to_send}, {24'h0, cmd_q.pop_front()});
            else check_eq("unexpected_send", {31'h0, send_byte}, 32'h0);
        end
        if (send_irq) begin
            if (pkt_q.size() > 0) check_eq("packet", {8'h0, m_status, m_dx, m_dy}, {8'h0, pkt_q.pop_front()});
            else check_eq("unexpected_irq", {31'h0, send_irq}, 32'h0);
        end
    end

    // Input tasks start and end #1 after a rising edge.
    task automatic pulse_sent();
        byte_sent = 1'b1;
        @(posedge clk); #1;
        byte_sent = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic [1:0] err);
        byte_read  = b;
        byte_err   = err;
        byte_ready = 1'b1;
        @(posedge clk); #1;
        byte_ready = 1'b0;
        byte_err   = 2'b00;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int lim);
        int n = 0;
        while (m_state != s && n < lim) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, {28'h0, m_state}, {28'h0, s});
    endtask

    // Reset, check cleared outputs, queue the reset command and release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_outputs", {send_byte, byte_to_send, read_enable, send_irq, m_state},
                 15'h0);
        check_eq("rst_mouse", {8'h0, m_status, m_dx, m_dy}, 32'h0);
        @(negedge clk);
        cmd_q.push_back(8'hFF);
        rst = 1'b0;
    endtask

    task automatic do_init();
        wait_state("st_wait_tx1", 4'd2, 30);
        check_eq("rd_en_on", {31'h0, read_enable}, 32'h1);
        pulse_sent();
        rx_byte(8'hFA, 2'b00);
        rx_byte(8'hAA, 2'b00);
        cmd_q.push_back(8'hF4);
        rx_byte(8'h00, 2'b00);
        wait_state("st_wait_tx2", 4'd7, 5);
        pulse_sent();
        rx_byte(8'hFA, 2'b00);
        check_eq("st_rx_stat", {28'h0, m_state}, 32'd9);
    endtask

    task automatic send_packet(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        pkt_q.push_back({s, x, y});
        rx_byte(s, 2'b00);
        rx_byte(x, 2'b00);
        rx_byte(y, 2'b00);
        check_eq("irq_not_early", {31'h0, send_irq}, 32'h0);
        @(posedge clk); #1;
        check_eq("irq_pulse", {31'h0, send_irq}, 32'h1);
        check_eq("pkt_direct", {8'h0, m_status, m_dx, m_dy}, {8'h0, s, x, y});
        @(posedge clk); #1;
        check_eq("irq_one_cycle", {31'h0, send_irq}, 32'h0);
    endtask

    initial begin
        // 1: reset command timing after release
        do_reset();
        repeat (InitDelay - 1) @(posedge clk);
        #1;
        check_eq("no_send_early", {31'h0, send_byte}, 32'h0);
        check_eq("rd_en_off", {31'h0, read_enable}, 32'h0);
        @(posedge clk); #1;
        check_eq("send_rst_pulse", {23'h0, send_byte, byte_to_send}, {23'h0, 1'b1, 8'hFF});
        check_eq("st_send_rst", {28'h0, m_state}, 32'd1);
        @(posedge clk); #1;
        check_eq("send_rst_1cyc", {31'h0, send_byte}, 32'h0);

        // 2/3: full init and packets
        do_init();
        send_packet(8'h08, 8'h05, 8'hFB);
        send_packet(8'h29, 8'hFF, 8'h01);

        // 4: bad BAT reply, retry delay, then init timeout
        do_reset();
        do_init_partial();

        // 5: error in the DX byte while streaming
        do_reset();
        do_init();
        send_packet(8'h08, 8'h05, 8'hFB);
        rx_byte(8'h09, 2'b00);
        rx_byte(8'h33, 2'b01);
        check_eq("err_to_init", {28'h0, m_state}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mouse_kept", {8'h0, m_status, m_dx, m_dy}, 32'h0008_05FB);
        check_eq("no_irq_err", {31'h0, send_irq}, 32'h0);
        cmd_q.push_back(8'hFF);
        wait_state("resend_after_err", 4'd2, 20);

        // 6: reset asserted mid-packet
        do_reset();
        do_init();
        send_packet(8'h10, 8'h7F, 8'h80);
        rx_byte(8'h2C, 2'b00);
        check_eq("st_rx_dx", {28'h0, m_state}, 32'd10);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_out", {send_byte, byte_to_send, read_enable, send_irq, m_state},
                 15'h0);
        check_eq("async_rst_mouse", {8'h0, m_status, m_dx, m_dy}, 32'h0);
        @(negedge clk);
        cmd_q.push_back(8'hFF);
        rst = 1'b0;
        do_init();
        send_packet(8'h01, 8'h02, 8'h03);

        repeat (3) @(posedge clk);
        #1;
        check_eq("cmd_q_drained", cmd_q.size(), 32'd0);
        check_eq("pkt_q_drained", pkt_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic do_init_partial();
        wait_state("t4_wait_tx1", 4'd2, 30);
        pulse_sent();
        rx_byte(8'hFA, 2'b00);
        rx_byte(8'hFC, 2'b00);
        check_eq("bad_bat_init", {28'h0, m_state}, 32'd0);
        check_eq("bad_bat_rd_off", {31'h0, read_enable}, 32'h0);
        cmd_q.push_back(8'hFF);
        repeat (InitDelay - 1) @(posedge clk);
        #1;
        check_eq("retry_still_init", {28'h0, m_state}, 32'd0);
        @(posedge clk); #1;
        check_eq("retry_send_rst", {28'h0, m_state}, 32'd1);
        @(posedge clk); #1;
        check_eq("retry_wait_tx1", {28'h0, m_state}, 32'd2);
        repeat (RxTimeout - 1) @(posedge clk);
        #1;
        check_eq("timeout_not_yet", {28'h0, m_state}, 32'd2);
        @(posedge clk); #1;
        check_eq("timeout_init", {28'h0, m_state}, 32'd0);
    endtask

endmodule
